exc_ctrl: RTL and testbench

Exception/interrupt sequencer for the CPU pipeline. It prioritises overflow, trap and external IRQ sources and drives the `exception` strobe into the interrupt address register. It steers the PC mux to the handler vector on entry, and back to the saved IAR address on return-from-exception. It also owns the global interrupt-enable and the per-IRQ mask register.

---
 rtl/exc_ctrl_pkg.sv | 29 ++
 rtl/exc_ctrl_irq_pri_enc.sv | 24 ++
 rtl/exc_ctrl.sv | 146 ++++++++++++++
 tb/tb_exc_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// rtl/exc_ctrl_pkg.sv - shared cause codes, FSM states and PC-mux selects for exc_ctrl
package exc_ctrl_pkg;

    localparam logic [3:0] CAUSE_NONE     = 4'd0;
    localparam logic [3:0] CAUSE_OVF      = 4'd1;
    localparam logic [3:0] CAUSE_TRAP     = 4'd2;
    localparam logic [3:0] CAUSE_IRQ_BASE = 4'd8;

    // Wide enough for up to 8 IRQ lines.
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTER   = 2'd1,
        HANDLER = 2'd2,
        RETURN  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PCSEL_SEQ = 2'b00,
        PCSEL_VEC = 2'b01,
        PCSEL_IAR = 2'b10
    } pc_sel_e;

    function automatic logic [3:0] irq_cause(input logic [IDX_W-1:0] idx);
        return CAUSE_IRQ_BASE + {1'b0, idx};
    endfunction

endpackage

// File: rtl/exc_ctrl_irq_pri_enc.sv
// rtl/exc_ctrl_irq_pri_enc.sv - combinational IRQ priority encoder, lowest index wins
module irq_pri_enc
    import exc_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Scan downwards so the last hit, the lowest set bit, is what remains.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt sequencer; define IRQ_EDGE_EN for edge-triggered IRQ pending
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] HANDLER_VEC = 32'h0000_0100,
    parameter logic [31:0] USER_BASE   = 32'h0001_0008
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               overflow,
    input  logic               trap,
    input  logic [31:0]        pc_8_in,
    input  logic               stall,
    input  logic               rfe,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic               exception,
    output logic               flush,
    output logic [1:0]         pc_sel,
    output logic [3:0]         cause,
    output logic               int_en,
    output logic               double_fault
);

    state_e             state, state_nxt;
    pc_sel_e            pc_sel_c;
    logic [NUM_IRQ-1:0] irq_mask;
    logic [NUM_IRQ-1:0] pending, pending_nxt;
    logic [NUM_IRQ-1:0] active;
    logic               irq_valid;
    logic [IDX_W-1:0]   irq_idx;
    logic               take;
    logic [3:0]         take_cause;

    generate
        if (NUM_IRQ < 1 || NUM_IRQ > 8) begin : g_bad_num_irq
            $error("exc_ctrl: NUM_IRQ must be 1..8");
        end
        if (HANDLER_VEC >= USER_BASE) begin : g_bad_vec
            $error("exc_ctrl: HANDLER_VEC must lie below USER_BASE");
        end
    endgenerate

    assign active = pending & irq_mask;

    irq_pri_enc #(.NUM_IRQ(NUM_IRQ)) u_pri_enc (
        .req   (active),
        .valid (irq_valid),
        .idx   (irq_idx)
    );

    // Sync faults need no int_en; handler code (below USER_BASE) is never interrupted.
    assign take = !stall && (pc_8_in >= USER_BASE) &&
                  (overflow || trap || (int_en && irq_valid));

    always_comb begin
        take_cause = CAUSE_NONE;
        if (overflow)
            take_cause = CAUSE_OVF;
        else if (trap)
            take_cause = CAUSE_TRAP;
        else
            take_cause = irq_cause(irq_idx);
    end

    always_comb begin
        state_nxt = state;
        exception = 1'b0;
        flush     = 1'b0;
        pc_sel_c  = PCSEL_SEQ;
        case (state)
            IDLE: begin
                if (take)
                    state_nxt = ENTER;
            end
            ENTER: begin
                exception = 1'b1;
                flush     = 1'b1;
                pc_sel_c  = PCSEL_VEC;
                state_nxt = HANDLER;
            end
            HANDLER: begin
                if (rfe && !stall)
                    state_nxt = RETURN;
            end
            RETURN: begin
                flush     = 1'b1;
                pc_sel_c  = PCSEL_IAR;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pc_sel = pc_sel_c;

`ifdef IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] irq_clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            irq_prev <= '0;
        else
            irq_prev <= irq;
    end

    // Only the line being serviced is cleared; a fresh rising edge wins over the clear.
    always_comb begin
        irq_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++)
            irq_clr[i] = (state == ENTER) && (cause == irq_cause(IDX_W'(i)));
        pending_nxt = (pending & ~irq_clr) | (irq & ~irq_prev);
    end
`else
    assign pending_nxt = irq;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            irq_mask     <= '0;
            pending      <= '0;
            cause        <= CAUSE_NONE;
            int_en       <= 1'b1;
            double_fault <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (mask_we)
                irq_mask <= mask_wdata;
            if (state == IDLE && take)
                cause <= take_cause;
            // Interrupts stay off from handler entry until the return cycle completes.
            if (state == ENTER)
                int_en <= 1'b0;
            else if (state == RETURN)
                int_en <= 1'b1;
            if (state == HANDLER && (overflow || trap))
                double_fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed scoreboard bench for exc_ctrl (level mode, or edge mode with IRQ_EDGE_EN)
module tb_exc_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq;
    logic         overflow;
    logic         trap;
    logic [31:0]  pc_8_in;
    logic         stall;
    logic         rfe;
    logic         mask_we;
    logic [N-1:0] mask_wdata;
    logic         exception;
    logic         flush;
    logic [1:0]   pc_sel;
    logic [3:0]   cause;
    logic         int_en;
    logic         double_fault;

    int           n_err     = 0;
    int           n_checks  = 0;
    int           exc_count = 0;
    logic [3:0]   exp_q[$];
    logic         prev_exc  = 1'b0;

    exc_ctrl #(
        .NUM_IRQ     (N),
        .HANDLER_VEC (32'h0000_0100),
        .USER_BASE   (32'h0001_0008)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .irq          (irq),
        .overflow     (overflow),
        .trap         (trap),
        .pc_8_in      (pc_8_in),
        .stall        (stall),
        .rfe          (rfe),
        .mask_we      (mask_we),
        .mask_wdata   (mask_wdata),
        .exception    (exception),
        .flush        (flush),
        .pc_sel       (pc_sel),
        .cause        (cause),
        .int_en       (int_en),
        .double_fault (double_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every exception strobe must match the oldest expected cause.
    always @(negedge clk) begin
        if (reset === 1'b1 && exception === 1'b1) begin
            exc_count++;
            check("strobe_pc_sel", 32'(pc_sel), 32'd1);
            check("strobe_flush", 32'(flush), 32'd1);
            check("strobe_width", 32'(prev_exc), 32'd0);
            check("spurious_exc", 32'(exp_q.size() == 0), 32'd0);
            if (exp_q.size() > 0)
                check("cause", 32'(cause), 32'(exp_q.pop_front()));
        end
        prev_exc = exception;
    end

    task automatic wait_exc(input string tag, input int lim);
        int start = exc_count;
        bit seen  = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            #1;
            if (exc_count != start)
                seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic no_exc(input string tag, input int n);
        int start = exc_count;
        repeat (n) @(negedge clk);
        #1;
        check(tag, 32'(exc_count - start), 32'd0);
    endtask

    task automatic wr_mask(input logic [N-1:0] v);
        mask_we    = 1'b1;
        mask_wdata = v;
        @(posedge clk);
        #1;
        mask_we = 1'b0;
    endtask

    task automatic do_rfe(input string tag);
        rfe = 1'b1;
        @(posedge clk);
        #1;
        rfe = 1'b0;
        @(negedge clk);
        check({tag, "_ret_pc_sel"}, 32'(pc_sel), 32'd2);
        check({tag, "_ret_flush"}, 32'(flush), 32'd1);
        @(negedge clk);
        check({tag, "_idle_pc_sel"}, 32'(pc_sel), 32'd0);
        check({tag, "_idle_int_en"}, 32'(int_en), 32'd1);
        check({tag, "_idle_flush"}, 32'(flush), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; irq = '0; overflow = 1'b0; trap = 1'b0; pc_8_in = '0;
        stall = 1'b0; rfe = 1'b0; mask_we = 1'b0; mask_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_int_en", 32'(int_en), 32'd1);
        check("rst_pc_sel", 32'(pc_sel), 32'd0);
        check("rst_cause", 32'(cause), 32'd0);
        check("rst_exception", 32'(exception), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_double_fault", 32'(double_fault), 32'd0);

        // Mask is all-zero after reset.
        pc_8_in = 32'h0001_0040;
        irq     = 4'b0001;
        no_exc("masked_after_reset", 5);
        irq = '0;

        // irq[0] entry and handler state.
        exp_q.push_back(4'd8);
        wr_mask(4'b0001);
        irq = 4'b0001;
        wait_exc("irq0_entry", 10);
        irq = '0;
        @(negedge clk);
        check("hnd_int_en", 32'(int_en), 32'd0);
        check("hnd_pc_sel", 32'(pc_sel), 32'd0);
        check("hnd_exception", 32'(exception), 32'd0);
        check("hnd_flush", 32'(flush), 32'd0);
        do_rfe("irq0");

        // Overflow beats trap; trap in handler is a double fault.
        pc_8_in  = 32'h0001_0100;
        overflow = 1'b1;
        trap     = 1'b1;
        exp_q.push_back(4'd1);
        wait_exc("ovf_entry", 5);
        overflow = 1'b0;
        trap     = 1'b0;
        @(negedge clk);
        check("ovf_hnd_int_en", 32'(int_en), 32'd0);
        trap = 1'b1;
        @(posedge clk);
        #1 trap = 1'b0;
        @(negedge clk);
        check("double_fault_set", 32'(double_fault), 32'd1);
        no_exc("double_fault_no_strobe", 4);
        check("double_fault_sticky", 32'(double_fault), 32'd1);
        do_rfe("ovf");

        // Handler region blocks entry; IRQ stays pending.
        wr_mask(4'b0010);
        pc_8_in = 32'h0000_0200;
        irq     = 4'b0010;
        no_exc("handler_region", 6);
        exp_q.push_back(4'd9);
        pc_8_in = 32'h0001_0010;
        wait_exc("irq1_entry", 5);
        irq = '0;
        @(negedge clk);
        do_rfe("irq1");

        // Stall defers entry.
        stall = 1'b1;
        irq   = 4'b0010;
        no_exc("stall_defer", 6);
        exp_q.push_back(4'd9);
        stall = 1'b0;
        wait_exc("stall_release", 5);
        irq = '0;
        @(negedge clk);

        // Stall defers the return.
        stall = 1'b1;
        rfe   = 1'b1;
        repeat (3) @(negedge clk);
        check("rfe_stalled_pc_sel", 32'(pc_sel), 32'd0);
        check("rfe_stalled_flush", 32'(flush), 32'd0);
        stall = 1'b0;
        @(posedge clk);
        #1 rfe = 1'b0;
        @(negedge clk);
        check("rfe_unstall_pc_sel", 32'(pc_sel), 32'd2);
        @(negedge clk);
        check("rfe_unstall_int_en", 32'(int_en), 32'd1);

        // Sync fault wins over a pending IRQ, which is then taken after return.
        stall = 1'b1;
        trap  = 1'b1;
        irq   = 4'b0010;
        repeat (3) @(negedge clk);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd9);
        stall = 1'b0;
        wait_exc("trap_over_irq", 5);
        trap = 1'b0;
        @(negedge clk);
        do_rfe("trap");
        wait_exc("irq_kept_pending", 5);
        irq = '0;
        @(negedge clk);
        do_rfe("irq_after_trap");

`ifdef IRQ_EDGE_EN
        wr_mask(4'b0001);
        irq = 4'b0001;
        exp_q.push_back(4'd8);
        wait_exc("edge_first", 6);
        @(negedge clk);
        do_rfe("edge_first");
        no_exc("edge_held_no_reentry", 6);
        irq = '0;
        @(negedge clk);
        irq = 4'b0001;
        exp_q.push_back(4'd8);
        wait_exc("edge_new_rise", 6);
        irq = '0;
        @(negedge clk);
        do_rfe("edge_second");
`else
        wr_mask(4'b0001);
        irq = 4'b0001;
        exp_q.push_back(4'd8);
        wait_exc("level_first", 6);
        @(negedge clk);
        do_rfe("level_first");
        exp_q.push_back(4'd8);
        wait_exc("level_reentry", 5);
        irq = '0;
        @(negedge clk);
        do_rfe("level_second");
`endif

        check("double_fault_still_set", 32'(double_fault), 32'd1);

        // Reset in the middle of a handler.
        trap = 1'b1;
        exp_q.push_back(4'd2);
        wait_exc("pre_reset_entry", 5);
        trap = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_pc_sel", 32'(pc_sel), 32'd0);
        check("midrst_int_en", 32'(int_en), 32'd1);
        check("midrst_double_fault", 32'(double_fault), 32'd0);
        check("midrst_cause", 32'(cause), 32'd0);
        check("midrst_flush", 32'(flush), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        no_exc("after_reset_idle", 4);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
